// File: rtl/kamacore_pkg.sv
// kamacore_pkg: shared widths, RV32 opcode/funct3 encodings and enums for the execute stage.
package kamacore_pkg;
    localparam int cpu_width      = 31;
    localparam int reg_addr_width = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [3:0] {
        ALU_ZERO, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;
endpackage

// File: rtl/kamacore_muldiv_iter.sv
// kamacore_muldiv_iter: fixed-latency RV32M unit; shift-add multiply and restoring divide on
// operand magnitudes, with the sign restored when the result is presented in DONE.
module kamacore_muldiv_iter import kamacore_pkg::*; #(
    parameter int W      = cpu_width + 1,
    parameter int CYCLES = cpu_width + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_hold,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_result
);
    localparam int CW = $clog2(CYCLES + 1);

    muldiv_state_t  r_state, w_next;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   r_a, r_b, r_hi, r_lo;
    logic [2:0]     r_op;
    logic           r_neg_q, r_neg_r, r_bzero;
    logic           w_last, w_a_neg, w_b_neg, w_ge;
    logic [W:0]     w_sum, w_shift;
    logic [W-1:0]   w_diff, w_quo, w_rem;
    logic [2*W-1:0] w_prod;

    assign w_last  = r_count == CW'(CYCLES);
    assign w_a_neg = i_a[W-1] & (i_op inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    assign w_b_neg = i_b[W-1] & (i_op inside {F3_MULH, F3_DIV, F3_REM});
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_shift = {r_hi, r_lo[W-1]};
    assign w_ge    = w_shift >= {1'b0, r_b};
    assign w_diff  = w_shift[W-1:0] - r_b;
    assign w_prod  = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo   = r_bzero ? '1 : (r_neg_q ? -r_lo : r_lo);
    assign w_rem   = r_neg_r ? -r_hi : r_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:    w_next = i_start ? BUSY : IDLE;
                BUSY:    w_next = w_last ? DONE : BUSY;
                DONE:    w_next = i_hold ? DONE : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy   = r_state == BUSY;
        o_done   = r_state == DONE;
        o_result = !r_op[2] ? ((r_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W])
                            : (r_op[1] ? w_rem : w_quo);
    end

    // hi/lo is the product for multiply, remainder/quotient for divide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
        end else if (r_state == IDLE && i_start && !i_clear) begin
            r_count <= '0;
            r_a     <= w_a_neg ? -i_a : i_a;
            r_b     <= w_b_neg ? -i_b : i_b;
            r_hi    <= '0;
            r_lo    <= i_op[2] ? (w_a_neg ? -i_a : i_a) : (w_b_neg ? -i_b : i_b);
            r_op    <= i_op;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bzero <= i_b == '0;
        end else if (r_state == BUSY && !w_last) begin
            r_count <= r_count + 1'b1;
            r_hi    <= r_op[2] ? (w_ge ? w_diff : w_shift[W-1:0]) : w_sum[W:1];
            r_lo    <= r_op[2] ? {r_lo[W-2:0], w_ge} : {w_sum[0], r_lo[W-1:1]};
        end
    end
endmodule

// File: rtl/kamacore_stage_ex.sv
// kamacore_stage_ex: execute stage; single-cycle ALU/address generation and an iterative
// mul/div unit feeding the registered EX/MEM bundle.
module kamacore_stage_ex import kamacore_pkg::*; #(
    parameter int CPU_WIDTH      = cpu_width,
    parameter int REG_ADDR_WIDTH = reg_addr_width,
    parameter int MULDIV_CYCLES  = cpu_width + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    hold,
    input  logic                    id_valid,
    input  logic [31:0]             instruction,
    input  logic [CPU_WIDTH:0]      data_a,
    input  logic [CPU_WIDTH:0]      data_b,
    input  logic [REG_ADDR_WIDTH:0] destination_register,
    input  logic                    control_alu_use_immediate,
    input  logic                    control_memory_read,
    input  logic                    control_memory_write,
    input  logic                    control_write_rd,
    input  logic                    control_write_register,
    output logic                    ex_busy,
    output logic                    mem_valid,
    output logic [CPU_WIDTH:0]      mem_result,
    output logic [CPU_WIDTH:0]      mem_store_data,
    output logic [REG_ADDR_WIDTH:0] mem_destination_register,
    output logic                    mem_control_memory_read,
    output logic                    mem_control_memory_write,
    output logic                    mem_control_write_rd,
    output logic                    mem_control_write_register
);
    localparam int W  = CPU_WIDTH + 1;
    localparam int SW = $clog2(W);

    logic [6:0]              w_opcode, w_f7;
    logic [2:0]              w_f3;
    logic                    w_muldiv, w_start, w_accept, w_idle, w_load_alu;
    logic                    w_md_busy, w_md_done;
    logic [W-1:0]            w_imm, w_op_b, w_alu_result, w_md_result;
    logic [SW-1:0]           w_shamt;
    alu_op_t                 w_alu_op;
    logic [3:0]              w_ctrl;
    logic [W-1:0]            r_md_store, r_result, r_store;
    logic [REG_ADDR_WIDTH:0] r_md_rd, r_rd;
    logic [3:0]              r_md_ctrl, r_ctrl;
    logic                    r_valid;

    assign w_opcode = instruction[6:0];
    assign w_f3     = instruction[14:12];
    assign w_f7     = instruction[31:25];
    assign w_muldiv = (w_opcode == OPC_OP) && (w_f7 == F7_MULDIV);
    assign w_ctrl   = {control_memory_read, control_memory_write, control_write_rd, control_write_register};
    assign w_imm    = (w_opcode == OPC_LUI) ? W'({instruction[31:12], 12'b0})
                    : control_memory_write ? {{(W-12){instruction[31]}}, instruction[31:25], instruction[11:7]}
                    : {{(W-12){instruction[31]}}, instruction[31:20]};
    assign w_op_b   = (control_alu_use_immediate || w_opcode inside {OPC_LUI, OPC_LOAD, OPC_STORE}) ? w_imm : data_b;
    assign w_shamt  = w_op_b[SW-1:0];

    always_comb begin
        w_alu_op = ALU_ZERO;
        case (w_opcode)
            OPC_OP, OPC_OPIMM: begin
                case (w_f3)
                    F3_ADD:  w_alu_op = (w_opcode == OPC_OP && w_f7[5]) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_alu_op = ALU_SLL;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_SR:   w_alu_op = w_f7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            OPC_LUI:             w_alu_op = ALU_PASS_B;
            OPC_LOAD, OPC_STORE: w_alu_op = ALU_ADD;
            default:             w_alu_op = ALU_ZERO;
        endcase
    end

    always_comb begin
        w_alu_result = '0;
        case (w_alu_op)
            ALU_ADD:    w_alu_result = data_a + w_op_b;
            ALU_SUB:    w_alu_result = data_a - w_op_b;
            ALU_SLL:    w_alu_result = data_a << w_shamt;
            ALU_SLT:    w_alu_result = {{(W-1){1'b0}}, $signed(data_a) < $signed(w_op_b)};
            ALU_SLTU:   w_alu_result = {{(W-1){1'b0}}, data_a < w_op_b};
            ALU_XOR:    w_alu_result = data_a ^ w_op_b;
            ALU_SRL:    w_alu_result = data_a >> w_shamt;
            ALU_SRA:    w_alu_result = $unsigned($signed(data_a) >>> w_shamt);
            ALU_OR:     w_alu_result = data_a | w_op_b;
            ALU_AND:    w_alu_result = data_a & w_op_b;
            ALU_PASS_B: w_alu_result = w_op_b;
            default:    w_alu_result = '0;
        endcase
    end

    kamacore_muldiv_iter #(.W(W), .CYCLES(MULDIV_CYCLES)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (clear),
        .i_hold   (hold),
        .i_start  (w_start),
        .i_op     (w_f3),
        .i_a      (data_a),
        .i_b      (data_b),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    assign w_start    = id_valid & w_muldiv;
    assign w_idle     = !w_md_busy && !w_md_done;
    assign w_accept   = w_idle && w_start && !clear;
    assign ex_busy    = w_md_busy | (w_md_done & hold) | (w_idle & w_start);
    assign w_load_alu = id_valid && !ex_busy && !w_md_done;

    // rd/controls of the mul/div are captured at accept so DONE does not depend on ID holding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_rd    <= '0;
            r_md_ctrl  <= '0;
            r_md_store <= '0;
        end else if (w_accept) begin
            r_md_rd    <= destination_register;
            r_md_ctrl  <= w_ctrl;
            r_md_store <= data_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_store  <= '0;
            r_rd     <= '0;
            r_ctrl   <= '0;
        end else if (!hold) begin
            r_valid  <= w_md_done | w_load_alu;
            r_result <= w_md_done ? w_md_result : (w_load_alu ? w_alu_result : '0);
            r_store  <= w_md_done ? r_md_store : (w_load_alu ? data_b : '0);
            r_rd     <= w_md_done ? r_md_rd : (w_load_alu ? destination_register : '0);
            r_ctrl   <= w_md_done ? r_md_ctrl : (w_load_alu ? w_ctrl : '0);
        end
    end

    assign mem_valid                  = r_valid;
    assign mem_result                 = r_result;
    assign mem_store_data             = r_store;
    assign mem_destination_register   = r_rd;
    assign {mem_control_memory_read, mem_control_memory_write,
            mem_control_write_rd, mem_control_write_register} = r_ctrl;
endmodule
